commit_sequencer: RTL and testbench

- Retires instructions from the RoB head, one per cycle at most.
- Drives the register-file commit write port: commit_valid, cdb_regid, cdb_value, cdb_RoBindex.
- Sequences store retirement through a req/ack handshake with the LSB.
- On a branch mispredict, pulses rf_clear and redirect to the front end. Sits between RoB and RegisterFile/LSB/IFetch.

---
 rtl/commit_sequencer_pkg.sv | 26 ++
 rtl/commit_sequencer.sv | 135 +++++++++++++
 tb/tb_commit_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_sequencer_pkg.sv
// ============================================================================
// Module      : commit_sequencer_pkg
// Description : Shared encodings for the commit sequencer (head types, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package commit_sequencer_pkg;

    localparam int c_rob_addr = 3;

    localparam logic [1:0] c_type_reg    = 2'b00;
    localparam logic [1:0] c_type_branch = 2'b01;
    localparam logic [1:0] c_type_store  = 2'b10;
    localparam logic [1:0] c_type_halt   = 2'b11;

    typedef enum logic [1:0] {
        c_st_idle       = 2'd0,
        c_st_store_wait = 2'd1,
        c_st_flush      = 2'd2,
        c_st_halted     = 2'd3
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/commit_sequencer.sv
// ============================================================================
// Module      : commit_sequencer
// Description : Retires RoB head entries: RF commit, store handshake, mispredict flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_sequencer
    import commit_sequencer_pkg::*;
#(
    parameter int ROB_ADDR = c_rob_addr,
    parameter int XLEN     = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                head_valid,
    input  logic                head_ready,
    input  logic [1:0]          head_type,
    input  logic [4:0]          head_rd,
    input  logic [XLEN-1:0]     head_value,
    input  logic [ROB_ADDR-1:0] head_idx,
    input  logic                head_mispred,
    input  logic [XLEN-1:0]     head_target,
    output logic                rob_pop,
    output logic                commit_valid,
    output logic [4:0]          cdb_regid,
    output logic [XLEN-1:0]     cdb_value,
    output logic [ROB_ADDR-1:0] cdb_RoBindex,
    output logic                st_req,
    output logic [ROB_ADDR-1:0] st_idx,
    input  logic                st_ack,
    output logic                rf_clear,
    output logic                redirect_valid,
    output logic [XLEN-1:0]     redirect_pc,
    output logic                halted,
    output logic [31:0]         commit_count
);

    seq_state_t          r_state;
    seq_state_t          w_next;
    logic                w_pop;
    logic                w_commit;
    logic                r_flush;
    logic                r_st_req;
    logic                r_halted;
    logic [ROB_ADDR-1:0] r_st_idx;
    logic [XLEN-1:0]     r_redirect_pc;
    logic [31:0]         r_commit_count;

    always_comb begin
        w_next   = r_state;
        w_pop    = 1'b0;
        w_commit = 1'b0;
        if (rdy_in) begin
            case (r_state)
                c_st_idle: begin
                    if (head_valid && head_ready) begin
                        case (head_type)
                            c_type_reg, c_type_branch: begin
                                w_pop    = 1'b1;
                                w_commit = (head_rd != 5'd0);
                                if (head_type == c_type_branch && head_mispred) begin
                                    w_next = c_st_flush;
                                end
                            end
                            c_type_store: begin
                                w_next = c_st_store_wait;
                            end
                            default: begin
                                w_pop  = 1'b1;
                                w_next = c_st_halted;
                            end
                        endcase
                    end
                end
                c_st_store_wait: begin
                    if (st_ack) begin
                        w_pop  = 1'b1;
                        w_next = c_st_idle;
                    end
                end
                c_st_flush: begin
                    w_next = c_st_idle;
                end
                default: begin
                    w_next = c_st_halted;
                end
            endcase
        end
    end

    // Flush is raised the cycle after the branch commits so its link write lands first.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state        <= c_st_idle;
            r_flush        <= 1'b0;
            r_st_req       <= 1'b0;
            r_halted       <= 1'b0;
            r_st_idx       <= '0;
            r_redirect_pc  <= '0;
            r_commit_count <= '0;
        end else if (rdy_in) begin
            r_state  <= w_next;
            r_flush  <= (w_next == c_st_flush);
            r_st_req <= (w_next == c_st_store_wait);
            r_halted <= (w_next == c_st_halted);
            if (r_state == c_st_idle && w_next == c_st_store_wait) begin
                r_st_idx <= head_idx;
            end
            if (r_state == c_st_idle && w_next == c_st_flush) begin
                r_redirect_pc <= head_target;
            end
            if (w_pop) begin
                r_commit_count <= r_commit_count + 32'd1;
            end
        end
    end

    assign rob_pop        = w_pop;
    assign commit_valid   = w_commit;
    assign cdb_regid      = head_rd;
    assign cdb_value      = head_value;
    assign cdb_RoBindex   = head_idx;
    assign st_req         = r_st_req;
    assign st_idx         = r_st_idx;
    assign rf_clear       = r_flush & rdy_in;
    assign redirect_valid = r_flush & rdy_in;
    assign redirect_pc    = r_redirect_pc;
    assign halted         = r_halted;
    assign commit_count   = r_commit_count;

endmodule

`default_nettype wire

// File: tb/tb_commit_sequencer.sv
// ============================================================================
// Module      : tb_commit_sequencer
// Description : Directed vector table, reset-abort sequence and random model check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_sequencer;

    localparam int ROB_ADDR = 3;
    localparam int XLEN     = 32;

    typedef struct packed {
        logic        rdy;
        logic        hv;
        logic        hr;
        logic [1:0]  ty;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [2:0]  idx;
        logic        mp;
        logic [31:0] tgt;
        logic        ack;
    } in_t;

    typedef struct packed {
        logic        pop;
        logic        cv;
        logic        sreq;
        logic [2:0]  sidx;
        logic        rfc;
        logic        rv;
        logic [31:0] rpc;
        logic        halt;
        logic [31:0] cnt;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic                clk_in;
    logic                rst_in;
    logic                rdy_in;
    logic                head_valid;
    logic                head_ready;
    logic [1:0]          head_type;
    logic [4:0]          head_rd;
    logic [XLEN-1:0]     head_value;
    logic [ROB_ADDR-1:0] head_idx;
    logic                head_mispred;
    logic [XLEN-1:0]     head_target;
    logic                rob_pop;
    logic                commit_valid;
    logic [4:0]          cdb_regid;
    logic [XLEN-1:0]     cdb_value;
    logic [ROB_ADDR-1:0] cdb_RoBindex;
    logic                st_req;
    logic [ROB_ADDR-1:0] st_idx;
    logic                st_ack;
    logic                rf_clear;
    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;
    logic                halted;
    logic [31:0]         commit_count;

    int total = 0;
    int bad   = 0;

    commit_sequencer #(.ROB_ADDR(ROB_ADDR), .XLEN(XLEN)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .head_valid     (head_valid),
        .head_ready     (head_ready),
        .head_type      (head_type),
        .head_rd        (head_rd),
        .head_value     (head_value),
        .head_idx       (head_idx),
        .head_mispred   (head_mispred),
        .head_target    (head_target),
        .rob_pop        (rob_pop),
        .commit_valid   (commit_valid),
        .cdb_regid      (cdb_regid),
        .cdb_value      (cdb_value),
        .cdb_RoBindex   (cdb_RoBindex),
        .st_req         (st_req),
        .st_idx         (st_idx),
        .st_ack         (st_ack),
        .rf_clear       (rf_clear),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .commit_count   (commit_count)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    function automatic vec_t mk(
        input logic rdy, input logic hv, input logic hr, input logic [1:0] ty,
        input logic [4:0] rd, input logic [31:0] val, input logic [2:0] idx,
        input logic mp, input logic [31:0] tgt, input logic ack,
        input logic pop, input logic cv, input logic sreq, input logic [2:0] sidx,
        input logic rfc, input logic rv, input logic [31:0] rpc, input logic halt,
        input logic [31:0] cnt);
        vec_t v;
        v.i = '{rdy, hv, hr, ty, rd, val, idx, mp, tgt, ack};
        v.e = '{pop, cv, sreq, sidx, rfc, rv, rpc, halt, cnt};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input in_t i);
        rdy_in       = i.rdy;
        head_valid   = i.hv;
        head_ready   = i.hr;
        head_type    = i.ty;
        head_rd      = i.rd;
        head_value   = i.val;
        head_idx     = i.idx;
        head_mispred = i.mp;
        head_target  = i.tgt;
        st_ack       = i.ack;
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, " rob_pop"},        64'(rob_pop),        64'(e.pop));
        chk({tag, " commit_valid"},   64'(commit_valid),   64'(e.cv));
        chk({tag, " st_req"},         64'(st_req),         64'(e.sreq));
        chk({tag, " st_idx"},         64'(st_idx),         64'(e.sidx));
        chk({tag, " rf_clear"},       64'(rf_clear),       64'(e.rfc));
        chk({tag, " redirect_valid"}, 64'(redirect_valid), 64'(e.rv));
        chk({tag, " redirect_pc"},    64'(redirect_pc),    64'(e.rpc));
        chk({tag, " halted"},         64'(halted),         64'(e.halt));
        chk({tag, " commit_count"},   64'(commit_count),   64'(e.cnt));
        chk({tag, " cdb_regid"},      64'(cdb_regid),      64'(head_rd));
        chk({tag, " cdb_value"},      64'(cdb_value),      64'(head_value));
        chk({tag, " cdb_RoBindex"},   64'(cdb_RoBindex),   64'(head_idx));
    endtask

    task automatic apply_check(input string tag, input vec_t v);
        set_in(v.i);
        #1;
        check_all(tag, v.e);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Asserts reset mid-cycle, checks the cleared outputs, releases after the next edge.
    task automatic do_reset(input string tag);
        set_in('{1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0});
        rst_in = 1'b0;
        #1;
        check_all(tag, '0);
        tick();
        rst_in = 1'b1;
    endtask

    // Reference model: pending-activity flags rather than a state register.
    bit          m_halt, m_store, m_flush;
    logic [2:0]  m_sidx;
    logic [31:0] m_tgt, m_cnt;

    task automatic model_reset();
        m_halt = 0; m_store = 0; m_flush = 0;
        m_sidx = '0; m_tgt = '0; m_cnt = '0;
    endtask

    function automatic exp_t model_expect(input in_t i);
        exp_t e;
        e.sreq = m_store;
        e.sidx = m_sidx;
        e.rfc  = i.rdy && m_flush;
        e.rv   = i.rdy && m_flush;
        e.rpc  = m_tgt;
        e.halt = m_halt;
        e.cnt  = m_cnt;
        e.pop  = 1'b0;
        e.cv   = 1'b0;
        if (i.rdy && !m_halt && !m_flush) begin
            if (m_store) begin
                e.pop = i.ack;
            end else if (i.hv && i.hr) begin
                e.pop = (i.ty != 2'b10);
                e.cv  = (i.ty == 2'b00 || i.ty == 2'b01) && (i.rd != 5'd0);
            end
        end
        return e;
    endfunction

    task automatic model_advance(input in_t i, input logic popped);
        if (i.rdy) begin
            if (popped) m_cnt = m_cnt + 32'd1;
            if (m_halt) begin
            end else if (m_flush) begin
                m_flush = 0;
            end else if (m_store) begin
                if (i.ack) m_store = 0;
            end else if (i.hv && i.hr) begin
                if (i.ty == 2'b01 && i.mp) begin
                    m_flush = 1;
                    m_tgt   = i.tgt;
                end else if (i.ty == 2'b10) begin
                    m_store = 1;
                    m_sidx  = i.idx;
                end else if (i.ty == 2'b11) begin
                    m_halt = 1;
                end
            end
        end
    endtask

    vec_t tbl[19];

    initial begin
        //               rdy hv hr ty rd val      idx mp tgt     ack | pop cv sr si rfc rv rpc     h cnt
        tbl[0]  = mk(1, 1, 1, 0, 5, 32'h11,  1, 0, 0,       0,  1, 1, 0, 0, 0, 0, 0,       0, 0);
        tbl[1]  = mk(1, 1, 1, 0, 0, 32'h22,  2, 0, 0,       0,  1, 0, 0, 0, 0, 0, 0,       0, 1);
        tbl[2]  = mk(1, 1, 1, 0, 7, 32'h33,  3, 0, 0,       0,  1, 1, 0, 0, 0, 0, 0,       0, 2);
        tbl[3]  = mk(1, 1, 0, 0, 5, 32'h44,  4, 0, 0,       0,  0, 0, 0, 0, 0, 0, 0,       0, 3);
        tbl[4]  = mk(1, 1, 1, 2, 0, 32'h0,   4, 0, 0,       0,  0, 0, 0, 0, 0, 0, 0,       0, 3);
        tbl[5]  = mk(1, 1, 1, 2, 0, 32'h0,   4, 0, 0,       0,  0, 0, 1, 4, 0, 0, 0,       0, 3);
        tbl[6]  = mk(1, 1, 1, 2, 0, 32'h0,   4, 0, 0,       0,  0, 0, 1, 4, 0, 0, 0,       0, 3);
        tbl[7]  = mk(1, 1, 1, 2, 0, 32'h0,   4, 0, 0,       1,  1, 0, 1, 4, 0, 0, 0,       0, 3);
        tbl[8]  = mk(1, 0, 0, 0, 0, 32'h0,   0, 0, 0,       0,  0, 0, 0, 4, 0, 0, 0,       0, 4);
        tbl[9]  = mk(1, 1, 1, 1, 1, 32'h104, 5, 1, 32'h200, 0,  1, 1, 0, 4, 0, 0, 0,       0, 4);
        tbl[10] = mk(1, 1, 1, 0, 3, 32'h99,  6, 0, 0,       0,  0, 0, 0, 4, 1, 1, 32'h200, 0, 5);
        tbl[11] = mk(1, 0, 0, 0, 0, 32'h0,   0, 0, 0,       0,  0, 0, 0, 4, 0, 0, 32'h200, 0, 5);
        tbl[12] = mk(0, 1, 1, 0, 9, 32'h55,  7, 0, 0,       0,  0, 0, 0, 4, 0, 0, 32'h200, 0, 5);
        tbl[13] = mk(0, 1, 1, 0, 9, 32'h55,  7, 0, 0,       0,  0, 0, 0, 4, 0, 0, 32'h200, 0, 5);
        tbl[14] = mk(1, 1, 1, 0, 9, 32'h55,  7, 0, 0,       0,  1, 1, 0, 4, 0, 0, 32'h200, 0, 5);
        tbl[15] = mk(1, 0, 0, 0, 0, 32'h0,   0, 0, 0,       1,  0, 0, 0, 4, 0, 0, 32'h200, 0, 6);
        tbl[16] = mk(1, 1, 1, 3, 0, 32'h0,   0, 0, 0,       0,  1, 0, 0, 4, 0, 0, 32'h200, 0, 6);
        tbl[17] = mk(1, 1, 1, 0, 2, 32'h77,  1, 0, 0,       0,  0, 0, 0, 4, 0, 0, 32'h200, 1, 7);
        tbl[18] = mk(1, 1, 1, 0, 2, 32'h77,  1, 0, 0,       0,  0, 0, 0, 4, 0, 0, 32'h200, 1, 7);

        rst_in = 1'b0;
        set_in('{1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0});
        repeat (2) @(posedge clk_in);
        #1;
        check_all("reset", '0);
        rst_in = 1'b1;

        for (int k = 0; k < 19; k++) begin
            apply_check($sformatf("row%0d", k), tbl[k]);
            tick();
        end

        // Reset taken while a store is outstanding; a late ack must not pop.
        do_reset("rst_from_halt");
        apply_check("pre_store_reg", mk(1, 1, 1, 0, 4, 32'h66, 2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tick();
        apply_check("store_issue",   mk(1, 1, 1, 2, 0, 32'h0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tick();
        apply_check("store_wait",    mk(1, 1, 1, 2, 0, 32'h0, 6, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 1));
        do_reset("rst_mid_store");
        apply_check("late_ack0",     mk(1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        apply_check("late_ack1",     mk(1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();

        model_reset();
        begin
            int halt_cycles;
            halt_cycles = 0;
            for (int c = 0; c < 800; c++) begin
                if ((m_halt && halt_cycles > 3) || ($urandom % 200 == 0)) begin
                    do_reset($sformatf("rnd_rst%0d", c));
                    model_reset();
                    halt_cycles = 0;
                end else begin
                    in_t  ri;
                    exp_t re;
                    int unsigned r;
                    r         = $urandom % 32;
                    ri.rdy    = ($urandom % 8) != 0;
                    ri.hv     = ($urandom % 4) != 0;
                    ri.hr     = ($urandom % 4) != 0;
                    ri.ty     = (r < 12) ? 2'b00 : (r < 22) ? 2'b01 : (r < 30) ? 2'b10 : 2'b11;
                    ri.rd     = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
                    ri.val    = $urandom;
                    ri.idx    = 3'($urandom);
                    ri.mp     = 1'($urandom);
                    ri.tgt    = $urandom;
                    ri.ack    = ($urandom % 3) == 0;
                    set_in(ri);
                    #1;
                    re = model_expect(ri);
                    check_all($sformatf("rnd%0d", c), re);
                    tick();
                    model_advance(ri, re.pop);
                    if (m_halt) halt_cycles++;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
